// File: rtl/iob_fifo_wr_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter family.
package iob_fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Bit width needed to hold indices 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping modulo N_REQ.
module iob_rr_pick
  import iob_fifo_wr_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk the distances from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      cand = IDX_W'((32'(ptr) + k) % N_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/iob_fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
module iob_fifo_wr_arb
  import iob_fifo_wr_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ATOMIC    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  input  logic [N_REQ-1:0]        last,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    fifo_w_en,
  output logic [DATA_W-1:0]       fifo_w_data,
  input  logic                    fifo_w_full,
  input  logic [ADDR_W-1:0]       fifo_w_level
);

  localparam int unsigned IDX_W = clog2_min1(N_REQ);
  localparam int unsigned CNT_W = clog2_min1(BURST_LEN + 1);
  localparam int unsigned DEPTH = (1 << ADDR_W) - 1;

  arb_state_e        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  burst_cnt;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [ADDR_W:0]   free;
  logic              ok_start;
  logic              active;
  logic              burst_done;
  logic [DATA_W-1:0] words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = data[i*DATA_W +: DATA_W];
  end

  iob_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Atomic mode only opens a burst when a full BURST_LEN of space is free.
  assign free     = (ADDR_W+1)'(DEPTH) - {1'b0, fifo_w_level};
  assign ok_start = (ATOMIC == 0) || (free >= (ADDR_W+1)'(BURST_LEN));

  assign busy        = (state == BURST);
  assign active      = busy && !rst;
  assign fifo_w_en   = active && req[idx] && !fifo_w_full;
  assign fifo_w_data = active ? words[idx] : '0;
  assign ack         = grant & {N_REQ{fifo_w_en}};
  assign burst_done  = !req[idx] ||
                       (fifo_w_en && (last[idx] || (burst_cnt == CNT_W'(BURST_LEN - 1))));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= IDX_W'(N_REQ - 1);
      idx       <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid && ok_start) begin
            state     <= BURST;
            grant     <= N_REQ'(1) << pick_idx;
            idx       <= pick_idx;
            burst_cnt <= '0;
          end
        end
        BURST: begin
          // The served index drops to lowest priority for the next pick.
          if (burst_done) begin
            state     <= IDLE;
            ptr       <= idx;
            grant     <= '0;
            burst_cnt <= '0;
          end else if (fifo_w_en) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
